ud_bfs_sched: RTL and testbench
===============================

// Module: ud_bfs_sched
// PURPOSE
//  Deterministic controller that decides unique decipherability of a code (Sardinas-Patterson BFS).
//  - Holds a writable 8-entry code table.
//  - Sequences the prefix/suffix compare datapath over a FIFO work queue of dangling suffixes.
//  - Keeps a visited set so no suffix is expanded twice.
//  - Reports unique / ambiguous / overflow. Replaces nondeterministic sel search with a scheduled sweep.
// PARAMETERS
//  QDEPTH  8   work-queue entries (power of 2)
//  VDEPTH  16  visited-set entries
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  cfg_we        in   1   code-table write strobe; ignored while busy
//  cfg_idx       in   3   table entry to write
//  cfg_word      in   16  code word: 3b/char (a=000..e=100), reversed, stop bit above last char; 0=unused
//  start         in   1   launch check; ignored while busy
//  busy          out  1   search in progress
//  done          out  1   verdict valid; held until next start
//  ambiguous     out  1   1 = code not uniquely decipherable
//  overflow      out  1   queue or visited set exhausted; verdict invalid
//  steps         out  16  SCAN cycles used, saturating at 0xFFFF
//  witness_word  out  16  dangling suffix equal to a code word (UD_WITNESS_EN)
//  witness_idx   out  3   matching table index (UD_WITNESS_EN)
// BEHAVIOUR
//  Reset: all outputs 0; queue/visited empty; FSM=IDLE.
//  Reset table: 0:0x0008 a, 1:0x000A c, 2:0x0058 ad, 3:0x0248 abb, 4:0x02C1 bad, 5:0x0263 deb, 6:0xC689 bbcde, 7:0.
//  Word helpers (4 lengths sel=0..3 = 1..4 chars):
//   pre(w,s): proper prefix of s+1 chars, or 0x7FFF if w has <=s+1 chars.
//   suf(w,s): w >> 3(s+1).
//  FSM states:
//   IDLE --start--> SEED: clear busy/done/flags/steps, queue, visited; busy=1.
//   SEED: one cycle per nonzero table entry; push entry with seed=1.
//    Seeds are not entered in visited. Then -> POP.
//   POP: queue empty -> DONE, ambiguous=0. Else pop {w,seed} into work register -> SCAN with i=0, s=0.
//   SCAN: one candidate (c=table[i], s) per cycle; zero entries skipped. steps++.
//    a) !seed && s==0 && w==c          -> ambiguous=1, -> DONE (highest priority).
//    b) else if c==pre(w,s)            -> n=suf(w,s).
//    c) else if pre(c,s)==w            -> n=suf(c,s).
//    - On b/c, n not in visited:
//      - Visited full or queue full -> overflow=1, -> DONE.
//      - Else insert n in visited, push {n,0}. Same cycle.
//    - Visited lookup is a parallel compare, 0 latency.
//    - Iterate s fastest, then i. After (7,3) -> POP. Worst case 32 cycles per pop.
//   DONE: busy=0, done=1. start -> SEED. rst_n low -> IDLE from any state.
//  - b and c mutually exclusive by length; b has priority.
//  - Queue: circular pointers, wrap at QDEPTH. Push and pop never occur in the same cycle.
//  - Table writes during busy are dropped. Write in IDLE/DONE takes effect next start.
//  - start and cfg_we in the same cycle: write lands first, then search uses the new table.
// CONFIGURATION
//  UD_WITNESS_EN defined:
//   - On rule (a), latch witness_word=w and witness_idx=i.
//   - Cleared on start.
//  UD_WITNESS_EN undefined:
//   - witness_word and witness_idx tied to 0.
//   - No witness storage.
// TESTING
//  - Reset table, start -> done, ambiguous=1, overflow=0.
//    - Chain d,bb -> cde -> de -> b -> ad.
//    - witness_word=0x0058, witness_idx=2.
//  - Write {0x0008 a, 0x0041 ba, 0x0049 bb}, rest 0, start -> done, ambiguous=0. Prefix code, queue drains.
//  - Write {0x0008 a, 0x0009 b, 0x0041 ba}, start -> ambiguous=1. witness 0x0008 or 0x0009 (UD_WITNESS_EN).
//  - Param QDEPTH=2, reset table -> overflow=1, done=1.
//  - Assert rst_n mid-SCAN -> busy=done=0 immediately.
//    Restart -> same verdict as first test.
//  - start and cfg_we while busy -> no restart, table unchanged. steps identical to clean run.

Source files
------------

// File: rtl/ud_bfs_sched_if.sv
// Configuration, launch and verdict bus of ud_bfs_sched.
// The master drives table writes and start; the slave (the scheduler) returns status and verdict.
interface ud_bfs_sched_if;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_word;
    logic        start;
    logic        busy;
    logic        done;
    logic        ambiguous;
    logic        overflow;
    logic [15:0] steps;
    logic [15:0] witness_word;
    logic [2:0]  witness_idx;

    modport master (
        output cfg_we, cfg_idx, cfg_word, start,
        input  busy, done, ambiguous, overflow, steps, witness_word, witness_idx
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_word, start,
        output busy, done, ambiguous, overflow, steps, witness_word, witness_idx
    );
endinterface

// File: rtl/ud_bfs_sched.sv
// Sardinas-Patterson unique-decipherability checker: scheduled BFS over dangling suffixes.
// Define UD_WITNESS_EN to latch the suffix/table index that proves ambiguity.
module ud_bfs_sched #(
    parameter int unsigned QDEPTH = 8,
    parameter int unsigned VDEPTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    ud_bfs_sched_if.slave bus
);
    localparam int unsigned QW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned QCW = $clog2(QDEPTH + 1);
    localparam int unsigned VW  = (VDEPTH > 1) ? $clog2(VDEPTH) : 1;
    localparam int unsigned VCW = $clog2(VDEPTH + 1);

    typedef enum logic [2:0] {StIdle, StSeed, StPop, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0][15:0] tbl_q;
    logic [16:0]      q_mem_q [QDEPTH];
    logic [QW-1:0]    q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [QCW-1:0]   q_cnt_q, q_cnt_d;
    logic [15:0]      vis_mem_q [VDEPTH];
    logic [VCW-1:0]   vis_cnt_q, vis_cnt_d;
    logic [15:0]      w_q, w_d;
    logic             seed_q, seed_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       s_q, s_d;
    logic             amb_q, amb_d, ovf_q, ovf_d;
    logic [15:0]      steps_q, steps_d;

    logic        busy, launch, tbl_we;
    logic        push_en, push_seed, vis_ins;
    logic [15:0] push_word, c_word, n_word;
    logic        hit_a, hit_b, hit_c, in_vis, q_full, vis_full;
    logic [3:0]  nz_first, nz_cur, nz_nxt;

    // Character count from the stop-bit position.
    function automatic logic [2:0] word_len(logic [15:0] w);
        if (w[15])      return 3'd5;
        else if (w[12]) return 3'd4;
        else if (w[9])  return 3'd3;
        else if (w[6])  return 3'd2;
        else if (w[3])  return 3'd1;
        else            return 3'd0;
    endfunction

    // Proper prefix of s+1 chars; 0x7FFF can never match a legal word.
    function automatic logic [15:0] pre(logic [15:0] w, logic [1:0] s);
        logic [2:0]  k;
        logic [15:0] r;
        k = {1'b0, s} + 3'd1;
        case (s)
            2'd0:    r = {12'b0, 1'b1, w[2:0]};
            2'd1:    r = {9'b0, 1'b1, w[5:0]};
            2'd2:    r = {6'b0, 1'b1, w[8:0]};
            default: r = {3'b0, 1'b1, w[11:0]};
        endcase
        if (word_len(w) <= k) r = 16'h7FFF;
        return r;
    endfunction

    function automatic logic [15:0] suf(logic [15:0] w, logic [1:0] s);
        case (s)
            2'd0:    return w >> 3;
            2'd1:    return w >> 6;
            2'd2:    return w >> 9;
            default: return w >> 12;
        endcase
    endfunction

    // {found, index} of the lowest nonzero table entry at or above 'from'.
    function automatic logic [3:0] next_nz(logic [7:0][15:0] t, logic [3:0] from);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (4'(k) >= from && t[k] != 16'd0) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    function automatic logic [QW-1:0] ptr_inc(logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign busy     = (state_q == StSeed) || (state_q == StPop) || (state_q == StScan);
    assign launch   = !busy && bus.start;
    assign tbl_we   = !busy && bus.cfg_we;
    assign q_full   = (q_cnt_q == QCW'(QDEPTH));
    assign vis_full = (vis_cnt_q == VCW'(VDEPTH));

    assign nz_first = next_nz(tbl_q, 4'd0);
    assign nz_cur   = next_nz(tbl_q, {1'b0, idx_q});
    assign nz_nxt   = next_nz(tbl_q, {1'b0, nz_cur[2:0]} + 4'd1);

    assign c_word = tbl_q[idx_q];
    assign hit_a  = !seed_q && (s_q == 2'd0) && (w_q == c_word);
    assign hit_b  = (c_word == pre(w_q, s_q));
    assign hit_c  = (pre(c_word, s_q) == w_q);
    assign n_word = hit_b ? suf(w_q, s_q) : suf(c_word, s_q);

    always_comb begin
        in_vis = 1'b0;
        for (int k = 0; k < VDEPTH; k++) begin
            if (VCW'(k) < vis_cnt_q && vis_mem_q[k] == n_word) in_vis = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_head_d  = q_head_q;
        q_tail_d  = q_tail_q;
        q_cnt_d   = q_cnt_q;
        vis_cnt_d = vis_cnt_q;
        w_d       = w_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        s_d       = s_q;
        amb_d     = amb_q;
        ovf_d     = ovf_q;
        steps_d   = steps_q;
        push_en   = 1'b0;
        push_seed = 1'b0;
        push_word = '0;
        vis_ins   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (launch) begin
                    state_d   = StSeed;
                    q_head_d  = '0;
                    q_tail_d  = '0;
                    q_cnt_d   = '0;
                    vis_cnt_d = '0;
                    idx_d     = 3'd0;
                    amb_d     = 1'b0;
                    ovf_d     = 1'b0;
                    steps_d   = '0;
                end
            end
            StSeed: begin
                if (!nz_cur[3]) begin
                    state_d = StPop;
                end else if (q_full) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    push_en   = 1'b1;
                    push_seed = 1'b1;
                    push_word = tbl_q[nz_cur[2:0]];
                    idx_d     = nz_nxt[2:0];
                    if (!nz_nxt[3]) state_d = StPop;
                end
            end
            StPop: begin
                if (q_cnt_q == '0 || !nz_first[3]) begin
                    state_d = StDone;
                end else begin
                    {seed_d, w_d} = q_mem_q[q_head_q];
                    q_head_d      = ptr_inc(q_head_q);
                    q_cnt_d       = q_cnt_q - QCW'(1);
                    idx_d         = nz_first[2:0];
                    s_d           = 2'd0;
                    state_d       = StScan;
                end
            end
            StScan: begin
                if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
                if (hit_a) begin
                    amb_d   = 1'b1;
                    state_d = StDone;
                end else if ((hit_b || hit_c) && !in_vis && (q_full || vis_full)) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    if ((hit_b || hit_c) && !in_vis) begin
                        push_en   = 1'b1;
                        push_word = n_word;
                        vis_ins   = 1'b1;
                    end
                    if (s_q != 2'd3) begin
                        s_d = s_q + 2'd1;
                    end else begin
                        s_d = 2'd0;
                        if (nz_nxt[3]) idx_d = nz_nxt[2:0];
                        else           state_d = StPop;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Pops only happen in POP and pushes never do, so the count updates cannot collide.
        if (push_en) begin
            q_tail_d = ptr_inc(q_tail_q);
            q_cnt_d  = q_cnt_q + QCW'(1);
        end
        if (vis_ins) vis_cnt_d = vis_cnt_q + VCW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            q_head_q  <= '0;
            q_tail_q  <= '0;
            q_cnt_q   <= '0;
            vis_cnt_q <= '0;
            w_q       <= '0;
            seed_q    <= 1'b0;
            idx_q     <= 3'd0;
            s_q       <= 2'd0;
            amb_q     <= 1'b0;
            ovf_q     <= 1'b0;
            steps_q   <= '0;
            tbl_q[0]  <= 16'h0008;
            tbl_q[1]  <= 16'h000A;
            tbl_q[2]  <= 16'h0058;
            tbl_q[3]  <= 16'h0248;
            tbl_q[4]  <= 16'h02C1;
            tbl_q[5]  <= 16'h0263;
            tbl_q[6]  <= 16'hC689;
            tbl_q[7]  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            q_head_q  <= q_head_d;
            q_tail_q  <= q_tail_d;
            q_cnt_q   <= q_cnt_d;
            vis_cnt_q <= vis_cnt_d;
            w_q       <= w_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            s_q       <= s_d;
            amb_q     <= amb_d;
            ovf_q     <= ovf_d;
            steps_q   <= steps_d;
            if (tbl_we) tbl_q[bus.cfg_idx] <= bus.cfg_word;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (push_en) q_mem_q[q_tail_q] <= {push_seed, push_word};
        if (vis_ins) vis_mem_q[vis_cnt_q[VW-1:0]] <= n_word;
    end

    assign bus.busy      = busy;
    assign bus.done      = (state_q == StDone);
    assign bus.ambiguous = amb_q;
    assign bus.overflow  = ovf_q;
    assign bus.steps     = steps_q;

`ifdef UD_WITNESS_EN
    logic [15:0] wit_word_q;
    logic [2:0]  wit_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wit_word_q <= '0;
            wit_idx_q  <= '0;
        end else if (launch) begin
            wit_word_q <= '0;
            wit_idx_q  <= '0;
        end else if (state_q == StScan && hit_a) begin
            wit_word_q <= w_q;
            wit_idx_q  <= idx_q;
        end
    end

    assign bus.witness_word = wit_word_q;
    assign bus.witness_idx  = wit_idx_q;
`else
    assign bus.witness_word = '0;
    assign bus.witness_idx  = '0;
`endif
endmodule

// File: tb/tb_ud_bfs_sched.sv
// Directed bench for ud_bfs_sched: a string-level Sardinas-Patterson model predicts every verdict.
module tb_ud_bfs_sched;
    localparam int VDEPTH = 16;

    logic clk;
    logic rst_n;
    ud_bfs_sched_if bus ();
    ud_bfs_sched_if bus2 ();

    ud_bfs_sched #(.QDEPTH(8), .VDEPTH(VDEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ud_bfs_sched #(.QDEPTH(2), .VDEPTH(VDEPTH)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tb_tbl [8];
    bit          e_amb, e_ovf, e2_amb, e2_ovf;
    int          e_steps, e2_steps;
    logic [15:0] e_ww, e2_ww;
    logic [2:0]  e_wi, e2_wi;
    bit          chk_en = 0, chk2_en = 0;
    logic        done_p = 0, done2_p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic string dec(logic [15:0] w);
        string r;
        int    top, n, ch;
        r   = "";
        top = 0;
        for (int b = 0; b < 16; b++) if (w[b]) top = b;
        n = top / 3;
        for (int j = 0; j < n; j++) begin
            ch = int'((w >> (3 * j)) & 16'h7);
            r  = {r, $sformatf("%c", 97 + ch)};
        end
        return r;
    endfunction

    function automatic logic [15:0] enc(string s);
        logic [15:0] r;
        r = 16'h0;
        for (int j = 0; j < s.len(); j++) r = r | (16'(s[j] - 8'd97) << (3 * j));
        r = r | (16'd1 << (3 * s.len()));
        return r;
    endfunction

    // Breadth-first dangling-suffix search on character strings.
    task automatic model_run(input int qdepth, output bit amb, output bit ovf, output int steps,
                             output logic [15:0] ww, output logic [2:0] wi);
        string qw[$];
        bit    qs[$];
        string vis[$];
        string w, c, n;
        bit    sd, seen, stop;
        int    k;
        amb = 0; ovf = 0; steps = 0; ww = 16'h0; wi = 3'h0; stop = 0;
        for (int i = 0; i < 8; i++) begin
            if (!stop && tb_tbl[i] != 16'h0) begin
                if (qw.size() == qdepth) begin ovf = 1; stop = 1; end
                else begin qw.push_back(dec(tb_tbl[i])); qs.push_back(1'b1); end
            end
        end
        while (!stop && qw.size() > 0) begin
            w  = qw.pop_front();
            sd = qs.pop_front();
            for (int i = 0; i < 8 && !stop; i++) begin
                if (tb_tbl[i] != 16'h0) begin
                    c = dec(tb_tbl[i]);
                    for (int s = 0; s < 4 && !stop; s++) begin
                        k = s + 1;
                        steps++;
                        if (!sd && s == 0 && w == c) begin
                            amb = 1; ww = enc(w); wi = 3'(i); stop = 1;
                        end else begin
                            n = "";
                            if (c.len() == k && w.len() > k && w.substr(0, k - 1) == c)
                                n = w.substr(k, w.len() - 1);
                            else if (w.len() == k && c.len() > k && c.substr(0, k - 1) == w)
                                n = c.substr(k, c.len() - 1);
                            if (n != "") begin
                                seen = 0;
                                foreach (vis[v]) if (vis[v] == n) seen = 1;
                                if (!seen) begin
                                    if (vis.size() == VDEPTH || qw.size() == qdepth) begin
                                        ovf = 1; stop = 1;
                                    end else begin
                                        vis.push_back(n); qw.push_back(n); qs.push_back(1'b0);
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
        if (steps > 65535) steps = 65535;
    endtask

    task automatic set_default_tbl();
        tb_tbl[0] = 16'h0008; tb_tbl[1] = 16'h000A; tb_tbl[2] = 16'h0058; tb_tbl[3] = 16'h0248;
        tb_tbl[4] = 16'h02C1; tb_tbl[5] = 16'h0263; tb_tbl[6] = 16'hC689; tb_tbl[7] = 16'h0000;
    endtask

    // Verdict check on each rising edge of done; flags must stay low while searching.
    always @(negedge clk) begin
        if (chk_en && bus.busy) chk("busy_flags", {bus.ambiguous, bus.overflow, bus.done}, 0);
        if (chk_en && bus.done && !done_p) begin
            chk("busy_at_done", bus.busy, 0);
            chk("ambiguous", bus.ambiguous, e_amb);
            chk("overflow", bus.overflow, e_ovf);
            chk("steps", bus.steps, e_steps);
`ifdef UD_WITNESS_EN
            chk("witness_word", bus.witness_word, e_ww);
            chk("witness_idx", bus.witness_idx, e_wi);
`else
            chk("witness_word", bus.witness_word, 0);
            chk("witness_idx", bus.witness_idx, 0);
`endif
        end
        if (chk2_en && bus2.done && !done2_p) begin
            chk("q2_ambiguous", bus2.ambiguous, e2_amb);
            chk("q2_overflow", bus2.overflow, e2_ovf);
            chk("q2_steps", bus2.steps, e2_steps);
`ifdef UD_WITNESS_EN
            chk("q2_witness_word", bus2.witness_word, e2_ww);
`else
            chk("q2_witness_word", bus2.witness_word, 0);
`endif
        end
        done_p  <= bus.done;
        done2_p <= bus2.done;
    end

    task automatic pulse_start(input bit both);
        @(posedge clk); #1;
        bus.start = 1'b1;
        if (both) bus2.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic write_tbl(input logic [2:0] idx, input logic [15:0] word);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_word = word;
        tb_tbl[idx] = word;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!bus.done) begin
            n_fail++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, cyc);
        end
        #1;
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_word = 0; bus.start = 0;
        bus2.cfg_we = 0; bus2.cfg_idx = 0; bus2.cfg_word = 0; bus2.start = 0;
        set_default_tbl();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ambiguous", bus.ambiguous, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_steps", bus.steps, 0);
        chk("rst_witness_word", bus.witness_word, 0);
        chk("rst_witness_idx", bus.witness_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset table: ambiguous via d,bb -> cde -> de -> b -> ad; shallow queue overflows.
        model_run(8, e_amb, e_ovf, e_steps, e_ww, e_wi);
        model_run(2, e2_amb, e2_ovf, e2_steps, e2_ww, e2_wi);
        chk("model_t1_ambiguous", e_amb, 1);
        chk("model_t1_overflow", e_ovf, 0);
        chk("model_t1_witness_word", e_ww, 16'h0058);
        chk("model_t1_witness_idx", e_wi, 2);
        chk("model_q2_overflow", e2_ovf, 1);
        chk_en = 1; chk2_en = 1;
        pulse_start(1'b1);
        wait_done("t1");
        chk("t1_ambiguous_lit", bus.ambiguous, 1);
        chk("q2_done_lit", bus2.done, 1);
        chk("q2_overflow_lit", bus2.overflow, 1);

        // start and cfg_we while busy are dropped; steps must match the clean run.
        pulse_start(1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_word = 16'h0009;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        chk("busy_kept", bus.busy, 1);
        wait_done("t4");
        pulse_start(1'b0);
        wait_done("t4_rerun");
        chk("t4_table_kept_lit", bus.ambiguous, 1);

        // Asynchronous reset in the middle of a scan, then a clean rerun.
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", bus.busy, 0);
        chk("mid_reset_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_default_tbl();
        pulse_start(1'b0);
        wait_done("t5");

        // Prefix code {a, ba, bb}: queue drains, unique.
        write_tbl(3'd0, 16'h0008);
        write_tbl(3'd1, 16'h0041);
        write_tbl(3'd2, 16'h0049);
        for (int i = 3; i < 8; i++) write_tbl(3'(i), 16'h0000);
        model_run(8, e_amb, e_ovf, e_steps, e_ww, e_wi);
        chk("model_t2_ambiguous", e_amb, 0);
        chk("model_t2_overflow", e_ovf, 0);
        pulse_start(1'b0);
        wait_done("t2");
        chk("t2_ambiguous_lit", bus.ambiguous, 0);

        // {a, b, ba}: last write shares the cycle with start and must be used.
        write_tbl(3'd1, 16'h0009);
        tb_tbl[2] = 16'h0041;
        model_run(8, e_amb, e_ovf, e_steps, e_ww, e_wi);
        chk("model_t3_ambiguous", e_amb, 1);
        chk("model_t3_witness_word", e_ww, 16'h0008);
        chk("model_t3_witness_idx", e_wi, 0);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd2; bus.cfg_word = 16'h0041; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        wait_done("t3");
        chk("t3_ambiguous_lit", bus.ambiguous, 1);
        chk("t3_overflow_lit", bus.overflow, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
